// File: rtl/control_riesgos_pkg.sv
// Shared definitions for the MIPS hazard controller: FSM state encoding and
// the hard-wired zero register number.
package paquete_mips;

    typedef enum logic {
        NORMAL = 1'b0,
        PARADA = 1'b1
    } estado_t;

    localparam logic [4:0] REG_CERO = 5'd0;

endpackage

// File: rtl/control_riesgos_contador_saturado.sv
// Saturating event counter: one increment per cycle with inc high, holds at all-ones.
// Latency: count visible the cycle after inc; no backpressure, inc is never refused.
module contador_saturado #(
    parameter int ANCHO = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [ANCHO-1:0] cuenta
);

    logic [ANCHO-1:0] cuenta_q;
    logic [ANCHO-1:0] cuenta_d;

    always_comb begin
        cuenta_d = cuenta_q;
        if (inc && (cuenta_q != {ANCHO{1'b1}})) begin
            cuenta_d = cuenta_q + ANCHO'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

    assign cuenta = cuenta_q;

endmodule

// File: rtl/control_riesgos.sv
// Load-use stall / jump-branch flush sequencer for PC, IF/ID and ID/EX.
// Latency: controls are Mealy (same cycle); stall lasts CICLOS_PARADA cycles, a taken branch overrides it.
module control_riesgos
    import paquete_mips::*;
#(
    parameter int CICLOS_PARADA = 1,
    parameter int ANCHO_CNT     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           id_rs,
    input  logic [4:0]           id_rt,
    input  logic                 id_usa_rt,
    input  logic                 id_salto,
    input  logic                 idex_mem_leer,
    input  logic [4:0]           idex_rt,
    input  logic                 ex_branch_tomado,
    output logic                 pc_escribir,
    output logic                 ifid_escribir,
    output logic                 ifid_limpiar,
    output logic                 idex_burbuja,
    output logic                 en_parada,
    output logic [ANCHO_CNT-1:0] cuenta_paradas,
    output logic [ANCHO_CNT-1:0] cuenta_vaciados
);

    localparam int ANCHO_PAR = (CICLOS_PARADA > 1) ? $clog2(CICLOS_PARADA) : 1;

    estado_t                estado_q;
    estado_t                estado_d;
    logic [ANCHO_PAR-1:0]   contador_q;
    logic [ANCHO_PAR-1:0]   contador_d;
    logic                   uso_carga;
    logic                   inc_paradas;
    logic                   inc_vaciados;

    assign uso_carga = idex_mem_leer && (idex_rt != REG_CERO) &&
                       ((idex_rt == id_rs) || (id_usa_rt && (idex_rt == id_rt)));

    always_comb begin
        estado_d      = estado_q;
        contador_d    = contador_q;
        pc_escribir   = 1'b1;
        ifid_escribir = 1'b1;
        ifid_limpiar  = 1'b0;
        idex_burbuja  = 1'b0;
        en_parada     = 1'b0;
        inc_paradas   = 1'b0;
        inc_vaciados  = 1'b0;
        if (rst) begin
            pc_escribir   = 1'b0;
            ifid_escribir = 1'b0;
            ifid_limpiar  = 1'b1;
            idex_burbuja  = 1'b1;
            estado_d      = NORMAL;
            contador_d    = '0;
        end else if (ex_branch_tomado) begin
            // A taken branch squashes whatever is in ID, including a held stall.
            ifid_limpiar  = 1'b1;
            idex_burbuja  = 1'b1;
            en_parada     = (estado_q == PARADA);
            inc_vaciados  = 1'b1;
            estado_d      = NORMAL;
            contador_d    = '0;
        end else if (estado_q == PARADA) begin
            pc_escribir   = 1'b0;
            ifid_escribir = 1'b0;
            idex_burbuja  = 1'b1;
            en_parada     = 1'b1;
            inc_paradas   = 1'b1;
            contador_d    = contador_q - ANCHO_PAR'(1);
            if (contador_q == ANCHO_PAR'(1)) begin
                estado_d = NORMAL;
            end
        end else if (uso_carga) begin
            pc_escribir   = 1'b0;
            ifid_escribir = 1'b0;
            idex_burbuja  = 1'b1;
            inc_paradas   = 1'b1;
            if (CICLOS_PARADA > 1) begin
                estado_d   = PARADA;
                contador_d = ANCHO_PAR'(CICLOS_PARADA - 1);
            end
        end else if (id_salto) begin
            ifid_limpiar  = 1'b1;
            inc_vaciados  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q   <= NORMAL;
            contador_q <= '0;
        end else begin
            estado_q   <= estado_d;
            contador_q <= contador_d;
        end
    end

    contador_saturado #(.ANCHO(ANCHO_CNT)) u_cnt_paradas (
        .clk    (clk),
        .rst    (rst),
        .inc    (inc_paradas),
        .cuenta (cuenta_paradas)
    );

    contador_saturado #(.ANCHO(ANCHO_CNT)) u_cnt_vaciados (
        .clk    (clk),
        .rst    (rst),
        .inc    (inc_vaciados),
        .cuenta (cuenta_vaciados)
    );

endmodule

// File: tb/tb_control_riesgos.sv
// Drives three hazard controllers (1, 3 and 4 stall cycles; the last with 2-bit
// counters) from shared stimulus and checks them against a per-cycle model.
module tb_control_riesgos;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, idex_rt;
    logic       id_usa_rt, id_salto, idex_mem_leer, ex_branch_tomado;

    logic [2:0]  pc_w, ife_w, lim_w, bur_w, ep_w;
    logic [15:0] cnt_par [3];
    logic [15:0] cnt_vac [3];

    int checks_total = 0;
    int checks_pass  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int CP = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        localparam int W  = (g == 2) ? 2 : 16;
        logic [W-1:0] c_par;
        logic [W-1:0] c_vac;
        control_riesgos #(.CICLOS_PARADA(CP), .ANCHO_CNT(W)) u_dut (
            .clk              (clk),
            .rst              (rst),
            .id_rs            (id_rs),
            .id_rt            (id_rt),
            .id_usa_rt        (id_usa_rt),
            .id_salto         (id_salto),
            .idex_mem_leer    (idex_mem_leer),
            .idex_rt          (idex_rt),
            .ex_branch_tomado (ex_branch_tomado),
            .pc_escribir      (pc_w[g]),
            .ifid_escribir    (ife_w[g]),
            .ifid_limpiar     (lim_w[g]),
            .idex_burbuja     (bur_w[g]),
            .en_parada        (ep_w[g]),
            .cuenta_paradas   (c_par),
            .cuenta_vaciados  (c_vac)
        );
        assign cnt_par[g] = 16'(c_par);
        assign cnt_vac[g] = 16'(c_vac);
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            checks_pass++;
        end
    endtask

    // Model: remaining bubbles still owed after the current one, plus event tallies.
    int ciclos [3] = '{1, 3, 4};
    int tope   [3] = '{65535, 65535, 3};
    int rem    [3];
    int par    [3];
    int vac    [3];
    bit modelo_valido = 1'b0;

    always @(negedge clk) begin
        bit uso;
        bit e_pc, e_ife, e_lim, e_bur, e_ep;
        uso = idex_mem_leer && (idex_rt != 5'd0) &&
              ((idex_rt == id_rs) || (id_usa_rt && (idex_rt == id_rt)));
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                e_pc = 0; e_ife = 0; e_lim = 1; e_bur = 1; e_ep = 0;
            end else if (ex_branch_tomado) begin
                e_pc = 1; e_ife = 1; e_lim = 1; e_bur = 1; e_ep = (rem[i] > 0);
            end else if (rem[i] > 0) begin
                e_pc = 0; e_ife = 0; e_lim = 0; e_bur = 1; e_ep = 1;
            end else if (uso) begin
                e_pc = 0; e_ife = 0; e_lim = 0; e_bur = 1; e_ep = 0;
            end else if (id_salto) begin
                e_pc = 1; e_ife = 1; e_lim = 1; e_bur = 0; e_ep = 0;
            end else begin
                e_pc = 1; e_ife = 1; e_lim = 0; e_bur = 0; e_ep = 0;
            end
            chk($sformatf("pc_escribir[%0d]", i),   16'(pc_w[i]),  16'(e_pc));
            chk($sformatf("ifid_escribir[%0d]", i), 16'(ife_w[i]), 16'(e_ife));
            chk($sformatf("ifid_limpiar[%0d]", i),  16'(lim_w[i]), 16'(e_lim));
            chk($sformatf("idex_burbuja[%0d]", i),  16'(bur_w[i]), 16'(e_bur));
            chk($sformatf("en_parada[%0d]", i),     16'(ep_w[i]),  16'(e_ep));
            if (modelo_valido) begin
                chk($sformatf("cuenta_paradas[%0d]", i),  cnt_par[i], 16'(par[i]));
                chk($sformatf("cuenta_vaciados[%0d]", i), cnt_vac[i], 16'(vac[i]));
            end
            if (rst) begin
                rem[i] = 0; par[i] = 0; vac[i] = 0;
            end else if (ex_branch_tomado) begin
                rem[i] = 0;
                if (vac[i] < tope[i]) vac[i]++;
            end else if (rem[i] > 0) begin
                rem[i]--;
                if (par[i] < tope[i]) par[i]++;
            end else if (uso) begin
                rem[i] = ciclos[i] - 1;
                if (par[i] < tope[i]) par[i]++;
            end else if (id_salto) begin
                if (vac[i] < tope[i]) vac[i]++;
            end
        end
        if (rst) modelo_valido = 1'b1;
    end

    task automatic drive(input bit r, input logic [4:0] rs, input logic [4:0] rt, input bit usa,
                         input bit salto, input bit mem, input logic [4:0] exrt, input bit br);
        @(posedge clk);
        #1;
        rst = r; id_rs = rs; id_rt = rt; id_usa_rt = usa; id_salto = salto;
        idex_mem_leer = mem; idex_rt = exrt; ex_branch_tomado = br;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        id_rs = 5'($urandom); id_rt = 5'($urandom); id_usa_rt = 1'($urandom);
        id_salto = 1'($urandom); idex_mem_leer = 1'($urandom); idex_rt = 5'($urandom);
        ex_branch_tomado = 1'($urandom);
        @(negedge clk);
        chk("rst pc_escribir", 16'(pc_w), 16'h0);
        chk("rst ifid_limpiar", 16'(lim_w), 16'h7);
        chk("rst idex_burbuja", 16'(bur_w), 16'h7);
        drive(1, 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 1'($urandom));
        idle(1);
        @(negedge clk);
        chk("rst cuenta_paradas", cnt_par[0], 16'd0);
        chk("rst cuenta_vaciados", cnt_vac[1], 16'd0);

        // load-use on rs
        drive(0, 8, 0, 0, 0, 1, 8, 0);
        @(negedge clk);
        chk("rs hazard pc", 16'(pc_w[0]), 16'd0);
        chk("rs hazard bubble", 16'(bur_w[0]), 16'd1);
        idle(5);
        @(negedge clk);
        chk("rs paradas cp1", cnt_par[0], 16'd1);
        chk("rs paradas cp3", cnt_par[1], 16'd3);
        chk("rs paradas cp4 w2", cnt_par[2], 16'd3);

        // r0 never hazards
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        chk("r0 no stall", 16'(pc_w), 16'h7);

        // load-use on rt
        drive(0, 4, 9, 1, 0, 1, 9, 0);
        @(negedge clk);
        chk("rt c1 pc", 16'(pc_w[1]), 16'd0);
        chk("rt c1 en_parada", 16'(ep_w[1]), 16'd0);
        idle(1);
        @(negedge clk);
        chk("rt c2 en_parada", 16'(ep_w[1]), 16'd1);
        idle(1);
        @(negedge clk);
        chk("rt c3 en_parada", 16'(ep_w[1]), 16'd1);
        chk("rt c3 pc", 16'(pc_w[1]), 16'd0);
        idle(1);
        @(negedge clk);
        chk("rt release cp3", 16'(pc_w[1]), 16'd1);
        chk("rt cp4 still held", 16'(pc_w[2]), 16'd0);
        idle(3);
        @(negedge clk);
        chk("rt paradas cp3", cnt_par[1], 16'd6);

        drive(0, 4, 9, 0, 0, 1, 9, 0);
        @(negedge clk);
        chk("rt unused no stall", 16'(pc_w), 16'h7);

        // jump, then branch racing a load-use
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        chk("jump limpiar", 16'(lim_w), 16'h7);
        chk("jump pc", 16'(pc_w), 16'h7);
        drive(0, 8, 0, 0, 0, 1, 8, 1);
        @(negedge clk);
        chk("branch beats stall pc", 16'(pc_w), 16'h7);
        chk("branch limpiar", 16'(lim_w), 16'h7);
        idle(1);
        @(negedge clk);
        chk("vaciados cp1", cnt_vac[0], 16'd2);
        chk("vaciados cp4", cnt_vac[2], 16'd2);

        // branch in second PARADA cycle
        drive(0, 8, 0, 0, 0, 1, 8, 0);
        idle(1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("abort limpiar cp4", 16'(lim_w[2]), 16'd1);
        idle(1);
        @(negedge clk);
        chk("abort en_parada cp4", 16'(ep_w[2]), 16'd0);
        chk("abort pc cp4", 16'(pc_w[2]), 16'd1);

        // reset in the middle of a stall
        drive(0, 8, 0, 0, 0, 1, 8, 0);
        idle(1);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("mid rst en_parada", 16'(ep_w), 16'h0);
        idle(1);
        @(negedge clk);
        chk("mid rst paradas", cnt_par[2], 16'd0);
        chk("mid rst vaciados", cnt_vac[2], 16'd0);
        chk("mid rst pc", 16'(pc_w), 16'h7);

        // saturation
        for (int h = 0; h < 5; h++) begin
            drive(0, 8, 0, 0, 0, 1, 8, 0);
            idle(4);
        end
        @(negedge clk);
        chk("sat paradas cp4 w2", cnt_par[2], 16'd3);
        chk("sat paradas cp1", cnt_par[0], 16'd5);
        chk("sat paradas cp3", cnt_par[1], 16'd15);

        idle(2);
        @(negedge clk);
        $display("%0d/%0d checks passed", checks_pass, checks_total);
        $finish;
    end

endmodule

// File: doc/control_riesgos.md
Name: control_riesgos

Overview:
- Hazard controller for the 5-stage MIPS pipeline. Sits beside the decode stage and sequences the PC, IF/ID and ID/EX registers.
- Detects load-use hazards and inserts a configurable number of bubbles.
- Flushes wrongly fetched instructions on ID-stage jumps and EX-resolved taken branches.
- Keeps saturating stall and flush counters for debug and performance.

Parameters:
- CICLOS_PARADA, 1, bubbles inserted per load-use hazard (>=1).
- ANCHO_CNT, 16, width of each statistics counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_usa_rt  in  1  ID instruction reads rt as a source (R-type, beq, sw)
- id_salto  in  1  jump decoded in ID (control unit salto)
- idex_mem_leer  in  1  instruction in EX is a load
- idex_rt  in  5  destination rt of instruction in EX
- ex_branch_tomado  in  1  branch in EX resolved taken this cycle
- pc_escribir  out  1  PC register load enable
- ifid_escribir  out  1  IF/ID load enable
- ifid_limpiar  out  1  IF/ID synchronous clear (inserts nop)
- idex_burbuja  out  1  zero all ID/EX control bits this cycle
- en_parada  out  1  high while in PARADA state
- cuenta_paradas  out  ANCHO_CNT  bubble cycles inserted for load-use
- cuenta_vaciados  out  ANCHO_CNT  flush events (jump + taken branch)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- While rst=1:
  - Outputs: pc_escribir=0, ifid_escribir=0, ifid_limpiar=1, idex_burbuja=1, en_parada=0.
  - Next edge: state=NORMAL, contador=0, both counters=0.
  - Reset during PARADA aborts the stall immediately.
- States: NORMAL, PARADA. Outputs are Mealy (combinational from state + inputs); state and counters are registered.
- uso_carga = idex_mem_leer & (idex_rt!=0) & ((idex_rt==id_rs) | (id_usa_rt & idex_rt==id_rt)). Register 0 never causes a hazard.
- Default outputs: pc_escribir=1, ifid_escribir=1, ifid_limpiar=0, idex_burbuja=0.
- Priority in NORMAL: ex_branch_tomado > uso_carga > id_salto.
  - ex_branch_tomado: ifid_limpiar=1, idex_burbuja=1, PC loads the target. cuenta_vaciados+1. Stay NORMAL.
  - uso_carga: pc_escribir=0, ifid_escribir=0, idex_burbuja=1, cuenta_paradas+1.
    - If CICLOS_PARADA==1, stay NORMAL.
    - Else go to PARADA with contador=CICLOS_PARADA-1.
  - id_salto (no hazard): ifid_limpiar=1, cuenta_vaciados+1. The ID instruction proceeds normally.
- PARADA:
  - Each cycle: pc_escribir=0, ifid_escribir=0, idex_burbuja=1, en_parada=1, cuenta_paradas+1, contador-1.
  - Return to NORMAL on the cycle contador==1.
  - uso_carga and id_salto are ignored in PARADA; the ID instruction is re-evaluated in NORMAL.
  - ex_branch_tomado in PARADA aborts the stall: NORMAL-flush outputs, cuenta_vaciados+1, next state NORMAL, contador=0.
- Latency:
  - Stall of CICLOS_PARADA cycles from hazard detection to release.
  - Flush takes effect at the same edge as the detection cycle.
- Counters saturate at 2^ANCHO_CNT-1 and never wrap.
- Simultaneous load-use and jump: the stall wins. The jump is handled on the release cycle, when the held instruction is still in ID.

Decomposition:
- Shared package paquete_mips:
  - State encoding localparams (NORMAL=1'b0, PARADA=1'b1).
  - REG_CERO=5'd0.
- One natural sub-module, contador_saturado (parameter ANCHO; ports clk, rst, inc, cuenta), instantiated twice.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> ifid_limpiar=1, idex_burbuja=1, pc_escribir=0; counters=0 after release.
- Load-use, CICLOS_PARADA=1: idex_mem_leer=1, idex_rt=8, id_rs=8 -> one cycle with pc_escribir=0, idex_burbuja=1; cuenta_paradas=1. Same stimulus with idex_rt=0 -> no stall.
- Load-use, CICLOS_PARADA=3: hazard on rt (id_usa_rt=1, id_rt=9=idex_rt) -> exactly 3 consecutive bubble cycles, en_parada high for cycles 2-3; cuenta_paradas=3. With id_usa_rt=0 -> no stall.
- Jump and branch: id_salto=1 -> ifid_limpiar=1 for 1 cycle, pc_escribir=1. ex_branch_tomado=1 together with uso_carga -> flush wins, no stall; cuenta_vaciados=2.
- Abort and reset mid-stall (CICLOS_PARADA=4):
  - ex_branch_tomado in the 2nd PARADA cycle -> flush, state NORMAL the next cycle.
  - rst in a PARADA cycle -> NORMAL, counters 0.
- Saturation (ANCHO_CNT=2): 5 load-use hazards -> cuenta_paradas holds at 3.
